// File: rtl/sample_addr_gen_if.sv
// Purpose: bundles the voice control inputs and the address/status outputs of sample_addr_gen.
// Latency: n/a (wires only).
// Backpressure: none; tick/trig/stop are single-cycle strobes and are never stalled.
//
// Signals:
//   tick    sample-rate enable strobe
//   trig    per-voice start/restart strobe
//   stop    per-voice abort strobe
//   loop    per-voice mode (1 = loop), captured at trig
//   len     per-voice last address (inclusive), voice i = len[i*AW +: AW], captured at trig
//   addr    per-voice current ROM address, same packing as len
//   active  voice i is playing
//   done    one-cycle pulse when voice i reaches its last address on a tick
//   nactive number of voices currently playing
interface sample_addr_gen_if #(
    parameter int NCH = 4,
    parameter int AW  = 18,
    parameter int CW  = 3
);
    logic                tick;
    logic [NCH-1:0]      trig;
    logic [NCH-1:0]      stop;
    logic [NCH-1:0]      loop;
    logic [NCH*AW-1:0]   len;
    logic [NCH*AW-1:0]   addr;
    logic [NCH-1:0]      active;
    logic [NCH-1:0]      done;
    logic [CW-1:0]       nactive;

    // Trigger/sequencer side drives controls and observes status.
    modport master (
        output tick, trig, stop, loop, len,
        input  addr, active, done, nactive
    );

    // Address generator side.
    modport slave (
        input  tick, trig, stop, loop, len,
        output addr, active, done, nactive
    );
endinterface

// File: rtl/sample_addr_gen.sv
// Purpose: NCH independent sample-playback address generators (one-shot or looped) for the sample ROMs.
// Latency: trig -> addr=0/active=1 one clk later; each later tick advances addr one clk later.
// Backpressure: none; every strobe is acted on in the cycle it is presented.
//
// Ports:
//   clk     system clock
//   resetn  asynchronous active-low reset
//   bus     sample_addr_gen_if.slave: tick/trig/stop/loop/len in, addr/active/done/nactive out
module sample_addr_gen #(
    parameter int NCH = 4,
    parameter int AW  = 18,
    parameter int CW  = 3
) (
    input  logic               clk,
    input  logic               resetn,
    sample_addr_gen_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t          state    [NCH];
    logic [AW-1:0]   addr_q   [NCH];
    logic [AW-1:0]   len_lat  [NCH];
    logic [NCH-1:0]  loop_lat;
    logic [NCH-1:0]  done_q;
    logic [NCH-1:0]  active_w;
    logic [CW-1:0]   nactive_w;

    // Per-voice state machine. Priority within a voice: trig > stop > tick > hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NCH; i++) begin
                state[i]   <= IDLE;
                addr_q[i]  <= '0;
                len_lat[i] <= '0;
            end
            loop_lat <= '0;
            done_q   <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                done_q[i] <= 1'b0;
                if (bus.trig[i]) begin
                    // Restart from 0; a coincident tick is deliberately ignored.
                    state[i]    <= PLAY;
                    addr_q[i]   <= '0;
                    len_lat[i]  <= bus.len[i*AW +: AW];
                    loop_lat[i] <= bus.loop[i];
                end else if (bus.stop[i]) begin
                    state[i]  <= IDLE;
                    addr_q[i] <= '0;
                end else if (bus.tick && state[i] == PLAY) begin
                    if (addr_q[i] == len_lat[i]) begin
                        // Last address reached: wrap for loop voices, park on the
                        // last address for one-shots. Never increments past len.
                        done_q[i] <= 1'b1;
                        if (loop_lat[i]) begin
                            addr_q[i] <= '0;
                        end else begin
                            state[i] <= IDLE;
                        end
                    end else begin
                        addr_q[i] <= addr_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign bus.addr[g*AW +: AW] = addr_q[g];
        assign active_w[g]          = (state[g] == PLAY);
    end

    // Population count of playing voices, straight from the state flops.
    always_comb begin
        nactive_w = '0;
        for (int i = 0; i < NCH; i++) begin
            nactive_w = nactive_w + CW'(active_w[i]);
        end
    end

    assign bus.active  = active_w;
    assign bus.done    = done_q;
    assign bus.nactive = nactive_w;

endmodule

// File: tb/tb_sample_addr_gen.sv
// Purpose: self-checking bench for sample_addr_gen (directed scenarios plus randomized run).
// Latency: n/a.
// Backpressure: n/a.
module tb_sample_addr_gen;
    localparam int NCH = 4;
    localparam int AW  = 18;
    localparam int CW  = 3;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;

    sample_addr_gen_if #(.NCH(NCH), .AW(AW), .CW(CW)) bus ();

    sample_addr_gen #(.NCH(NCH), .AW(AW), .CW(CW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a voice is described by how many ticks it has consumed
    // since its last trig. Address and status follow from plain arithmetic.
    bit m_has  [NCH];   // triggered and not since stopped/reset
    int m_t    [NCH];   // ticks consumed since trig
    int m_len  [NCH];
    bit m_loop [NCH];
    bit m_done [NCH];

    function automatic bit m_playing(int i);
        return m_has[i] && (m_loop[i] || m_t[i] <= m_len[i]);
    endfunction

    function automatic int m_addr(int i);
        if (!m_has[i]) return 0;
        if (m_loop[i]) return m_t[i] % (m_len[i] + 1);
        return (m_t[i] > m_len[i]) ? m_len[i] : m_t[i];
    endfunction

    function automatic logic [NCH*AW-1:0] exp_addr();
        logic [NCH*AW-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*AW +: AW] = AW'(m_addr(i));
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_active();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_playing(i);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_done();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_done[i];
        return v;
    endfunction

    function automatic logic [CW-1:0] exp_nactive();
        int c;
        c = 0;
        for (int i = 0; i < NCH; i++) c += m_playing(i) ? 1 : 0;
        return CW'(c);
    endfunction

    function automatic logic [NCH*AW-1:0] pack_len(int l0, int l1, int l2, int l3);
        logic [NCH*AW-1:0] v;
        v = {AW'(l3), AW'(l2), AW'(l1), AW'(l0)};
        return v;
    endfunction

    function automatic int dut_addr(int i);
        logic [NCH*AW-1:0] a;
        a = bus.addr;
        return int'(a[i*AW +: AW]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_has[i] = 0; m_t[i] = 0; m_len[i] = 0; m_loop[i] = 0; m_done[i] = 0;
        end
    endtask

    task automatic model_step(input logic tk, input logic [NCH-1:0] tg, input logic [NCH-1:0] sp,
                              input logic [NCH-1:0] lp, input logic [NCH*AW-1:0] ln);
        for (int i = 0; i < NCH; i++) begin
            m_done[i] = 0;
            if (tg[i]) begin
                m_has[i] = 1; m_t[i] = 0; m_len[i] = int'(ln[i*AW +: AW]); m_loop[i] = lp[i];
            end else if (sp[i]) begin
                m_has[i] = 0; m_t[i] = 0;
            end else if (tk && m_playing(i)) begin
                m_t[i] = m_t[i] + 1;
                if (m_t[i] % (m_len[i] + 1) == 0) m_done[i] = 1;
            end
        end
    endtask

    // One clock: present inputs, let the edge happen, advance the model, settle.
    task automatic cyc(input logic tk, input logic [NCH-1:0] tg, input logic [NCH-1:0] sp,
                       input logic [NCH-1:0] lp, input logic [NCH*AW-1:0] ln);
        bus.tick = tk; bus.trig = tg; bus.stop = sp; bus.loop = lp; bus.len = ln;
        @(posedge clk);
        model_step(tk, tg, sp, lp, ln);
        #1;
        bus.tick = 1'b0; bus.trig = '0; bus.stop = '0;
    endtask

    task automatic test_reset();
        if (bus.addr !== '0 || bus.active !== '0 || bus.done !== '0 || bus.nactive !== '0) begin
            $display("FAIL reset_init: addr=%h active=%b done=%b nactive=%0d, required all 0",
                     bus.addr, bus.active, bus.done, bus.nactive);
            n_fail++;
        end
        n_checks++;
        #2 resetn = 1'b1;
        cyc(1'b0, 4'b0001, '0, '0, pack_len(20, 0, 0, 0));
        for (int k = 0; k < 7; k++) cyc(1'b1, '0, '0, '0, pack_len(20, 0, 0, 0));
        if (dut_addr(0) !== 7) begin
            $display("FAIL reset_preaddr: addr0=%0d required 7", dut_addr(0)); n_fail++;
        end
        n_checks++;
        #2 resetn = 1'b0;
        #1;
        model_reset();
        if (bus.addr !== '0 || bus.active !== '0 || bus.done !== '0 || bus.nactive !== '0) begin
            $display("FAIL reset_async: addr=%h active=%b done=%b nactive=%0d, required all 0",
                     bus.addr, bus.active, bus.done, bus.nactive);
            n_fail++;
        end
        n_checks++;
        #1 resetn = 1'b1;
    endtask

    task automatic test_oneshot();
        int exp_a [5] = '{1, 2, 3, 3, 3};
        bit exp_d [5] = '{0, 0, 0, 1, 0};
        bit exp_v [5] = '{1, 1, 1, 0, 0};
        cyc(1'b0, 4'b0001, '0, 4'b0000, pack_len(3, 0, 0, 0));
        if (dut_addr(0) !== 0 || bus.active[0] !== 1'b1) begin
            $display("FAIL oneshot_start: addr0=%0d active0=%b required 0/1", dut_addr(0), bus.active[0]);
            n_fail++;
        end
        n_checks++;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, '0, '0, '0, pack_len(3, 0, 0, 0));
            if (dut_addr(0) !== exp_a[k] || bus.done[0] !== exp_d[k] || bus.active[0] !== exp_v[k]) begin
                $display("FAIL oneshot_tick%0d: addr0=%0d done0=%b active0=%b required %0d/%b/%b",
                         k + 1, dut_addr(0), bus.done[0], bus.active[0], exp_a[k], exp_d[k], exp_v[k]);
                n_fail++;
            end
            n_checks++;
        end
    endtask

    task automatic test_loop();
        int exp_a [7] = '{1, 2, 0, 1, 2, 0, 1};
        bit exp_d [7] = '{0, 0, 1, 0, 0, 1, 0};
        cyc(1'b0, 4'b0010, '0, 4'b0010, pack_len(0, 2, 0, 0));
        if (dut_addr(1) !== 0 || bus.active[1] !== 1'b1) begin
            $display("FAIL loop_start: addr1=%0d active1=%b required 0/1", dut_addr(1), bus.active[1]);
            n_fail++;
        end
        n_checks++;
        for (int k = 0; k < 7; k++) begin
            cyc(1'b1, '0, '0, '0, pack_len(0, 2, 0, 0));
            if (dut_addr(1) !== exp_a[k] || bus.done[1] !== exp_d[k] || bus.active[1] !== 1'b1) begin
                $display("FAIL loop_tick%0d: addr1=%0d done1=%b active1=%b required %0d/%b/1",
                         k + 1, dut_addr(1), bus.done[1], bus.active[1], exp_a[k], exp_d[k]);
                n_fail++;
            end
            n_checks++;
        end
        cyc(1'b0, '0, 4'b0010, '0, '0);
    endtask

    task automatic test_retrig_stop();
        cyc(1'b0, 4'b0100, '0, '0, pack_len(0, 0, 100, 0));
        for (int k = 0; k < 50; k++) cyc(1'b1, '0, '0, '0, pack_len(0, 0, 100, 0));
        if (dut_addr(2) !== 50) begin
            $display("FAIL retrig_pre: addr2=%0d required 50", dut_addr(2)); n_fail++;
        end
        n_checks++;
        cyc(1'b1, 4'b0100, 4'b0100, '0, pack_len(0, 0, 100, 0));
        if (dut_addr(2) !== 0 || bus.active[2] !== 1'b1 || bus.done[2] !== 1'b0) begin
            $display("FAIL retrig_restart: addr2=%0d active2=%b done2=%b required 0/1/0",
                     dut_addr(2), bus.active[2], bus.done[2]);
            n_fail++;
        end
        n_checks++;
        for (int k = 0; k < 3; k++) cyc(1'b1, '0, '0, '0, pack_len(0, 0, 100, 0));
        cyc(1'b1, '0, 4'b0100, '0, pack_len(0, 0, 100, 0));
        if (dut_addr(2) !== 0 || bus.active[2] !== 1'b0 || bus.done[2] !== 1'b0) begin
            $display("FAIL stop_idle: addr2=%0d active2=%b done2=%b required 0/0/0",
                     dut_addr(2), bus.active[2], bus.done[2]);
            n_fail++;
        end
        n_checks++;
        cyc(1'b1, '0, '0, '0, '0);
        if (dut_addr(2) !== 0 || bus.done[2] !== 1'b0) begin
            $display("FAIL stop_hold: addr2=%0d done2=%b required 0/0", dut_addr(2), bus.done[2]);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_concurrency();
        localparam int L3 = 3000;
        cyc(1'b0, 4'b1111, '0, 4'b0000, pack_len(0, 1, 5, L3));
        if (bus.nactive !== 3'd4 || bus.active !== 4'b1111) begin
            $display("FAIL conc_start: nactive=%0d active=%b required 4/1111", bus.nactive, bus.active);
            n_fail++;
        end
        n_checks++;
        cyc(1'b1, '0, '0, '0, '0);
        if (bus.done !== 4'b0001 || bus.nactive !== 3'd3) begin
            $display("FAIL conc_tick1: done=%b nactive=%0d required 0001/3", bus.done, bus.nactive);
            n_fail++;
        end
        n_checks++;
        cyc(1'b1, '0, '0, '0, '0);
        if (bus.done !== 4'b0010 || bus.nactive !== 3'd2) begin
            $display("FAIL conc_tick2: done=%b nactive=%0d required 0010/2", bus.done, bus.nactive);
            n_fail++;
        end
        n_checks++;
        for (int k = 3; k <= L3; k++) cyc(1'b1, '0, '0, '0, '0);
        if (dut_addr(3) !== L3 || bus.active !== 4'b1000 || bus.done !== 4'b0000) begin
            $display("FAIL conc_last: addr3=%0d active=%b done=%b required %0d/1000/0000",
                     dut_addr(3), bus.active, bus.done, L3);
            n_fail++;
        end
        n_checks++;
        cyc(1'b1, '0, '0, '0, '0);
        if (dut_addr(3) !== L3 || bus.done !== 4'b1000 || bus.nactive !== 3'd0) begin
            $display("FAIL conc_done3: addr3=%0d done=%b nactive=%0d required %0d/1000/0",
                     dut_addr(3), bus.done, bus.nactive, L3);
            n_fail++;
        end
        n_checks++;
        cyc(1'b1, '0, '0, '0, '0);
        if (dut_addr(3) !== L3 || bus.done !== 4'b0000) begin
            $display("FAIL conc_nowrap: addr3=%0d done=%b required %0d/0000", dut_addr(3), bus.done, L3);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_tick_coincident();
        cyc(1'b1, 4'b1000, '0, '0, pack_len(0, 0, 0, 4));
        if (dut_addr(3) !== 0 || bus.active[3] !== 1'b1) begin
            $display("FAIL coinc_tick: addr3=%0d active3=%b required 0/1", dut_addr(3), bus.active[3]);
            n_fail++;
        end
        n_checks++;
        // Shrinking len on the input mid-play must not cut the pass short.
        for (int k = 0; k < 3; k++) cyc(1'b1, '0, '0, 4'b1000, pack_len(0, 0, 0, 1));
        if (dut_addr(3) !== 3 || bus.done[3] !== 1'b0) begin
            $display("FAIL len_change: addr3=%0d done3=%b required 3/0", dut_addr(3), bus.done[3]);
            n_fail++;
        end
        n_checks++;
        cyc(1'b1, '0, '0, 4'b1000, pack_len(0, 0, 0, 1));
        cyc(1'b1, '0, '0, 4'b1000, pack_len(0, 0, 0, 1));
        if (dut_addr(3) !== 4 || bus.done[3] !== 1'b1 || bus.active[3] !== 1'b0) begin
            $display("FAIL len_latched_done: addr3=%0d done3=%b active3=%b required 4/1/0",
                     dut_addr(3), bus.done[3], bus.active[3]);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_random();
        logic              tk;
        logic [NCH-1:0]    tg, sp, lp;
        logic [NCH*AW-1:0] ln;
        int                errs;
        errs = 0;
        for (int n = 0; n < 2000; n++) begin
            tk = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < NCH; i++) begin
                tg[i] = ($urandom_range(0, 9) == 0);
                sp[i] = ($urandom_range(0, 15) == 0);
                lp[i] = $urandom_range(0, 1);
                ln[i*AW +: AW] = AW'($urandom_range(0, 6));
            end
            cyc(tk, tg, sp, lp, ln);
            if (bus.addr !== exp_addr()) begin
                if (errs < 10) $display("FAIL rand_addr cyc%0d: addr=%h required %h", n, bus.addr, exp_addr());
                n_fail++; errs++;
            end
            n_checks++;
            if (bus.active !== exp_active()) begin
                if (errs < 10) $display("FAIL rand_active cyc%0d: active=%b required %b", n, bus.active, exp_active());
                n_fail++; errs++;
            end
            n_checks++;
            if (bus.done !== exp_done()) begin
                if (errs < 10) $display("FAIL rand_done cyc%0d: done=%b required %b", n, bus.done, exp_done());
                n_fail++; errs++;
            end
            n_checks++;
            if (bus.nactive !== exp_nactive()) begin
                if (errs < 10) $display("FAIL rand_nactive cyc%0d: nactive=%0d required %0d", n, bus.nactive, exp_nactive());
                n_fail++; errs++;
            end
            n_checks++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        bus.tick = 1'b0; bus.trig = '0; bus.stop = '0; bus.loop = '0; bus.len = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_oneshot();
        test_loop();
        test_retrig_stop();
        test_concurrency();
        test_tick_coincident();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
